// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bus carried from the VGA timing generator
// to the ball and other raster consumers, plus the connector sync pins.
interface vga_timing_if;

   logic       pixpulse;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic       hsync;
   logic       vsync;
   logic       blank;
   logic       move;

   // The timing generator drives every signal of the bus
   modport master (
      output pixpulse,
      output hcount,
      output vcount,
      output hsync,
      output vsync,
      output blank,
      output move
   );

   // Raster consumers only observe the bus
   modport slave (
      input pixpulse,
      input hcount,
      input vcount,
      input hsync,
      input vsync,
      input blank,
      input move
   );

endinterface

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 Hz raster timing generator.
// Divides the system clock down to the pixel rate, steps the horizontal and
// vertical counters once per pixel, and produces registered sync, blank and
// a once-per-MOVE_FRAMES move strobe. Every registered output is computed
// from the next-state counter values so it always agrees with the counters
// currently on the bus.
module vga_timing #(
   parameter int CLK_DIV     = 4,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int MOVE_FRAMES = 1
) (
   input  logic         clk,
   input  logic         rst,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [4:0] DIV_LAST   = 5'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [7:0] FRAME_LAST = 8'(MOVE_FRAMES - 1);

   logic [4:0] div;
   logic [4:0] div_next;
   logic       pixpulse;
   logic       pix_next;

   logic [9:0] hcount;
   logic [9:0] vcount;
   logic [9:0] h_next;
   logic [9:0] v_next;

   logic       hsync;
   logic       vsync;
   logic       blank;
   logic       hsync_next;
   logic       vsync_next;
   logic       blank_next;

   logic [7:0] frame_cnt;
   logic [7:0] frame_next;
   logic       move;
   logic       move_next;
   logic       vblank_start;

   // Pixel divider: count 0..CLK_DIV-1 and flag the last count one clock
   // ahead so the registered strobe lines up with div == CLK_DIV-1
   always_comb begin
      div_next = (div == DIV_LAST) ? 5'd0 : div + 5'd1;
      pix_next = (div_next == DIV_LAST);
   end

   // Divider and pixel strobe registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div      <= 5'd0;
         pixpulse <= 1'b0;
      end else begin
         div      <= div_next;
         pixpulse <= pix_next;
      end
   end

   // Next raster position: step once per pixel strobe, carrying the
   // horizontal wrap into the line counter
   always_comb begin
      h_next = hcount;
      v_next = vcount;
      if (pixpulse) begin
         if (hcount == H_LAST) begin
            h_next = 10'd0;
            v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
         end else begin
            h_next = hcount + 10'd1;
         end
      end
   end

   // Raster position registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcount <= 10'd0;
         vcount <= 10'd0;
      end else begin
         hcount <= h_next;
         vcount <= v_next;
      end
   end

   // Sync and blank decode from the next position so they move in lockstep
   // with the counters instead of lagging one pixel behind
   always_comb begin
      hsync_next = !((h_next >= HS_START) && (h_next < HS_END));
      vsync_next = !((v_next >= VS_START) && (v_next < VS_END));
      blank_next = (h_next >= H_ACT) || (v_next >= V_ACT);
   end

   // Sync and blank registers; syncs idle high, blank low at (0,0)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         blank <= 1'b0;
      end else begin
         hsync <= hsync_next;
         vsync <= vsync_next;
         blank <= blank_next;
      end
   end

   // Move strobe: at the step into (0, V_ACTIVE) advance the frame counter
   // and raise move when the counter was at zero; drop it on the next step
   // so it covers exactly one pixel strobe inside vertical blanking
   always_comb begin
      vblank_start = pixpulse && (h_next == 10'd0) && (v_next == V_ACT);
      frame_next   = frame_cnt;
      move_next    = move;
      if (vblank_start) begin
         frame_next = (frame_cnt >= FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
         move_next  = (frame_cnt == 8'd0);
      end else if (pixpulse) begin
         move_next  = 1'b0;
      end
   end

   // Frame counter and move registers; reset discards any pending strobe
   // so the next one lands on the first vertical blank after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= 8'd0;
         move      <= 1'b0;
      end else begin
         frame_cnt <= frame_next;
         move      <= move_next;
      end
   end

   // Drive the raster bus
   assign vga.pixpulse = pixpulse;
   assign vga.hcount   = hcount;
   assign vga.vcount   = vcount;
   assign vga.hsync    = hsync;
   assign vga.vsync    = vsync;
   assign vga.blank    = blank;
   assign vga.move     = move;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing.
// dut_a runs the full 640x480 geometry for the startup and line checks;
// dut_b and dut_c use a shrunken 32x12 raster (16/4/8/4, 6/2/2/2) so whole
// frames fit in a short run, with MOVE_FRAMES of 3 and 1 respectively.
module tb_vga_timing;

   logic clk;
   logic rst;

   int checks;
   int failures;

   int hs_low_a;
   int blank_a;
   int line1_cycle_a;
   int vs_low_c;
   int move_pp_c;
   int move_clk_c;
   int wrap1_c;
   int wrap2_c;
   int prev_zero_c;
   int vb_count_b;
   int prev_vb_b;
   int move_mask_b;
   int found;
   int first_move_c;

   vga_timing_if bus_a ();
   vga_timing_if bus_b ();
   vga_timing_if bus_c ();

   vga_timing #(
      .CLK_DIV(4)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .vga(bus_a)
   );

   vga_timing #(
      .CLK_DIV(4), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .MOVE_FRAMES(3)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .vga(bus_b)
   );

   vga_timing #(
      .CLK_DIV(4), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .MOVE_FRAMES(1)
   ) dut_c (
      .clk(clk),
      .rst(rst),
      .vga(bus_c)
   );

   // 100 MHz system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison point: count it and report tag/observed/expected on failure
   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Closed-form raster reference for CLK_DIV = 4, cycle n counted from
   // reset release (cycle n ends at clock edge n):
   // {pixpulse, hsync, vsync, blank, move, hcount[9:0], vcount[9:0]}
   function automatic logic [31:0] expect_raster(input int n, input int ha,
      input int hfp, input int hsy, input int hbp, input int va, input int vfp,
      input int vsy, input int vbp, input int mf);
      int s, ht, vt, h, v, fr;
      logic pp, hs, vs, bl, mv;
      ht = ha + hfp + hsy + hbp;
      vt = va + vfp + vsy + vbp;
      s  = (n - 1) / 4;
      h  = s % ht;
      v  = (s / ht) % vt;
      fr = s / (ht * vt);
      pp = (n % 4 == 0);
      hs = !((h >= ha + hfp) && (h < ha + hfp + hsy));
      vs = !((v >= va + vfp) && (v < va + vfp + vsy));
      bl = (h >= ha) || (v >= va);
      mv = (h == 0) && (v == va) && (fr % mf == 0);
      return {7'd0, pp, hs, vs, bl, mv, 10'(h), 10'(v)};
   endfunction

   function automatic logic [31:0] pack_bus(input logic pp, input logic hs,
      input logic vs, input logic bl, input logic mv, input logic [9:0] h,
      input logic [9:0] v);
      return {7'd0, pp, hs, vs, bl, mv, h, v};
   endfunction

   // Directed sequence: reset, startup, line/frame/move runs, mid-frame reset
   initial begin
      checks        = 0;
      failures      = 0;
      hs_low_a      = 0;
      blank_a       = 0;
      line1_cycle_a = 0;
      vs_low_c      = 0;
      move_pp_c     = 0;
      move_clk_c    = 0;
      wrap1_c       = 0;
      wrap2_c       = 0;
      prev_zero_c   = 0;
      vb_count_b    = 0;
      prev_vb_b     = 0;
      move_mask_b   = 0;
      found         = 0;
      first_move_c  = 0;
      rst           = 1'b0;

      repeat (3) @(negedge clk);
      check_output("reset_a", pack_bus(bus_a.pixpulse, bus_a.hsync, bus_a.vsync,
                   bus_a.blank, bus_a.move, bus_a.hcount, bus_a.vcount),
                   pack_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0));
      check_output("reset_b", pack_bus(bus_b.pixpulse, bus_b.hsync, bus_b.vsync,
                   bus_b.blank, bus_b.move, bus_b.hcount, bus_b.vcount),
                   pack_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0));

      // Startup: pixpulse in cycles 4, 8, 12; hcount steps on those edges
      rst = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         check_output("pixpulse_startup", 32'(bus_a.pixpulse), 32'(n % 4 == 0));
         check_output("hcount_startup", 32'(bus_a.hcount), 32'((n - 1) / 4));
         @(negedge clk);
      end

      // Long run: every cycle of all three rasters against the reference
      for (int n = 13; n <= 10600; n++) begin
         check_output("raster_a", pack_bus(bus_a.pixpulse, bus_a.hsync, bus_a.vsync,
                      bus_a.blank, bus_a.move, bus_a.hcount, bus_a.vcount),
                      expect_raster(n, 640, 16, 96, 48, 480, 10, 2, 33, 1));
         check_output("raster_b", pack_bus(bus_b.pixpulse, bus_b.hsync, bus_b.vsync,
                      bus_b.blank, bus_b.move, bus_b.hcount, bus_b.vcount),
                      expect_raster(n, 16, 4, 8, 4, 6, 2, 2, 2, 3));
         check_output("raster_c", pack_bus(bus_c.pixpulse, bus_c.hsync, bus_c.vsync,
                      bus_c.blank, bus_c.move, bus_c.hcount, bus_c.vcount),
                      expect_raster(n, 16, 4, 8, 4, 6, 2, 2, 2, 1));

         if (bus_a.pixpulse && bus_a.vcount == 10'd0 && !bus_a.hsync) hs_low_a++;
         if (bus_a.pixpulse && bus_a.vcount == 10'd0 && bus_a.blank) blank_a++;
         if (line1_cycle_a == 0 && bus_a.hcount == 10'd0 && bus_a.vcount == 10'd1)
            line1_cycle_a = n;

         if (bus_c.pixpulse && !bus_c.vsync && n <= 1536) vs_low_c++;
         if (bus_c.move) move_clk_c++;
         if (bus_c.move && bus_c.pixpulse) move_pp_c++;
         if (bus_c.hcount == 10'd0 && bus_c.vcount == 10'd0 && prev_zero_c == 0) begin
            if (wrap1_c == 0) wrap1_c = n;
            else if (wrap2_c == 0) wrap2_c = n;
         end
         prev_zero_c = (bus_c.hcount == 10'd0 && bus_c.vcount == 10'd0) ? 1 : 0;

         if (bus_b.hcount == 10'd0 && bus_b.vcount == 10'd6 && prev_vb_b == 0)
            vb_count_b++;
         prev_vb_b = (bus_b.hcount == 10'd0 && bus_b.vcount == 10'd6) ? 1 : 0;
         if (bus_b.move && bus_b.pixpulse) move_mask_b = move_mask_b | (1 << vb_count_b);

         @(negedge clk);
      end

      check_output("hsync_low_line0", 32'(hs_low_a), 32'd96);
      check_output("blank_line0", 32'(blank_a), 32'd160);
      check_output("line_wrap_cycle", 32'(line1_cycle_a), 32'd3201);
      check_output("vsync_low_frame0", 32'(vs_low_c), 32'd64);
      check_output("frame_wrap_cycle", 32'(wrap1_c), 32'd1537);
      check_output("frame_length", 32'(wrap2_c - wrap1_c), 32'd1536);
      check_output("move_pp_mf1", 32'(move_pp_c), 32'd7);
      check_output("move_clocks_mf1", 32'(move_clk_c), 32'd28);
      check_output("vblank_count_mf3", 32'(vb_count_b), 32'd7);
      check_output("move_frames_mf3", 32'(move_mask_b), 32'h92);

      // Mid-frame reset while the move strobe is high
      for (int k = 0; k < 2000 && found == 0; k++) begin
         if (bus_c.move) found = 1;
         else @(negedge clk);
      end
      check_output("move_seen_before_reset", 32'(found), 32'd1);
      rst = 1'b0;
      #1;
      check_output("async_reset_c", pack_bus(bus_c.pixpulse, bus_c.hsync, bus_c.vsync,
                   bus_c.blank, bus_c.move, bus_c.hcount, bus_c.vcount),
                   pack_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0));
      @(negedge clk);
      rst = 1'b1;
      for (int n = 1; n <= 900; n++) begin
         if (n == 5)
            check_output("restart_position", 32'({bus_c.vcount, bus_c.hcount}),
                         32'({10'd0, 10'd1}));
         if (bus_c.move && first_move_c == 0) first_move_c = n;
         @(negedge clk);
      end
      check_output("move_after_reset_cycle", 32'(first_move_c), 32'd769);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the 640x480@60 Hz VGA raster timing from the 100 MHz system clock: the pixel-rate strobe, the horizontal/vertical pixel counters, the sync pulses, the blanking flag and a once-per-N-frames move strobe. It drives the `pixpulse`, `hcount`, `vcount` and `move` inputs of the ball and other raster consumers, and the sync pins of the VGA connector.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; range 2..16.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal pixels. H_TOTAL = sum = 800.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical lines. V_TOTAL = sum = 525.
- `MOVE_FRAMES`, 1: frames between move strobes; range 1..255.

- `clk`  in  1  100 MHz system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pixpulse`  out  1  one-`clk`-wide strobe every CLK_DIV clocks.
- `hcount`  out  10  current pixel column, 0..H_TOTAL-1.
- `vcount`  out  10  current line, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `blank`  out  1  high outside the 640x480 active area.
- `move`  out  1  held high for exactly one pixel period per MOVE_FRAMES frames.

## Operation
- Clock divider `div` counts 0..CLK_DIV-1 and wraps. `pixpulse` is registered and is high in the clock where `div` == CLK_DIV-1.
- On each `clk` edge where `pixpulse` is high:
  - `hcount` increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, `vcount` increments, wrapping V_TOTAL-1 -> 0.
- All other outputs are registered. Each is derived from the next-state counter values, so it changes on the same edge as the counters and always matches the `hcount`/`vcount` on the bus.
  - `hsync` = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - `vsync` = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - `blank` = (hcount >= H_ACTIVE) | (vcount >= V_ACTIVE).
- Move strobe:
  - 8-bit `frame_cnt` counts 0..MOVE_FRAMES-1. It advances when the counters step to (hcount=0, vcount=V_ACTIVE), i.e. at the start of vertical blanking.
  - `move` rises on that same edge only if `frame_cnt` was 0 before advancing. It falls on the next counter step (hcount=1).
  - A consumer that samples `move` qualified by `pixpulse` therefore sees exactly one move per strobe, during blanking. Its neighbour scan then restarts cleanly on the next active frame.
- No enable input; the raster runs continuously whenever `rst` is deasserted.

## Timing
- Reset values, asserted immediately while `rst` = 0:
  - `div` = 0, `pixpulse` = 0, `hcount` = 0, `vcount` = 0, `frame_cnt` = 0.
  - `hsync` = 1, `vsync` = 1, `blank` = 0, `move` = 0.
- After `rst` rises:
  - First `pixpulse` is at the CLK_DIV-th clock edge; `div` = CLK_DIV-1 on that cycle.
  - First counter step is on the edge ending that cycle: `hcount` 0 -> 1.
- `hcount`/`vcount`/`hsync`/`vsync`/`blank`/`move` change only on the edge that ends a `pixpulse` cycle. They are stable for a full CLK_DIV clocks, including the whole `pixpulse` cycle.
- Line period: H_TOTAL*CLK_DIV = 3200 clk. Frame period: 525*3200 = 1,680,000 clk.
- `move` high time: CLK_DIV clocks, covering exactly one `pixpulse`. Period: MOVE_FRAMES frames.
- Simultaneous wraps at (799, 524) -> (0, 0): both counters wrap on one edge. `blank` deasserts on that edge; `vsync` stays high.
- Reset mid-frame: all state returns to reset values asynchronously. Any in-progress `move` strobe is dropped, and `frame_cnt` restarts so the next strobe is at the first vertical blank after reset.
- MOVE_FRAMES = 1: `move` is strobed every frame; `frame_cnt` stays at 0.

## Test plan
- Reset then release; run 12 clocks -> all outputs at reset values while in reset; `pixpulse` high at clocks 4, 8, 12 only; `hcount` reads 1, 2, 3 after those edges.
- Run one full line -> `hsync` low for exactly 96 pixpulses (`hcount` 656..751); `blank` high for `hcount` 640..799; `hcount` wraps 799 -> 0 with `vcount` 0 -> 1.
- Run one full frame -> `vsync` low only for `vcount` 490..491 (1600 pixpulses); wrap (799, 524) -> (0, 0) on a single edge; frame length 1,680,000 clk.
- MOVE_FRAMES = 1 -> exactly one `pixpulse` with `move` = 1 per frame, at hcount=0, vcount=480; `move` high for exactly 4 clk.
- MOVE_FRAMES = 3 over 7 frames -> move strobes in frames 1, 4 and 7 only.
- Pull `rst` low at (hcount=0, vcount=480) while `move` is high, then release -> `move` drops immediately; counters restart at (0, 0); next `move` arrives 480*800 pixpulses after the first counter step.
